// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Holds the pipeline via stallreq while a MULT/DIV is in flight; MTHI/MTLO complete in one cycle.
module muldiv_hilo #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         annul,
  output logic         stallreq,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         hilo_we,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  localparam int unsigned MUL_STEPS = W / MUL_BPC;
  localparam int unsigned CNT_W     = $clog2(W + 1);
  localparam int unsigned PP_W      = W + MUL_BPC;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic           is_mul_q, is_mul_d;
  logic           neg_hi_q, neg_hi_d;
  logic           neg_lo_q, neg_lo_d;
  logic [W-1:0]   hi_q, lo_q;

  // Opcode decode and operand magnitudes (signs only for MULT/DIV)
  logic         op_mul, op_div, op_mthi, op_mtlo, op_signed;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_mthi   = (op == OP_MTHI);
  assign op_mtlo   = (op == OP_MTLO);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & src_a[W-1];
  assign b_neg     = op_signed & src_b[W-1];
  assign a_mag     = a_neg ? (~src_a + W'(1)) : src_a;
  assign b_mag     = b_neg ? (~src_b + W'(1)) : src_b;

  // Multiply step: acc = {partial sum, remaining multiplier bits}, opb = multiplicand
  logic [PP_W-1:0] mul_pp;
  logic [PP_W-1:0] mul_sum;
  logic [2*W-1:0]  mul_next;

  always_comb begin
    mul_pp = '0;
    for (int unsigned i = 0; i < MUL_BPC; i++) begin
      if (acc_q[i]) begin
        mul_pp = mul_pp + (PP_W'(opb_q) << i);
      end
    end
    mul_sum  = PP_W'(acc_q[2*W-1:W]) + mul_pp;
    mul_next = (2*W)'({mul_sum, acc_q[W-1:0]} >> MUL_BPC);
  end

  // Restoring divide step: acc = {remainder, dividend/quotient}, opb = divisor
  logic [W:0]     div_trial;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;

  always_comb begin
    div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    if (!div_diff[W]) begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  // Sign correction applied in DONE; a product negates as one 2W-bit value
  logic [2*W-1:0] full_neg;
  logic [W-1:0]   hi_neg, lo_neg, res_hi, res_lo;

  always_comb begin
    full_neg = ~acc_q + (2*W)'(1);
    hi_neg   = ~acc_q[2*W-1:W] + W'(1);
    lo_neg   = ~acc_q[W-1:0] + W'(1);
    if (is_mul_q) begin
      res_hi = neg_lo_q ? full_neg[2*W-1:W] : acc_q[2*W-1:W];
    end else begin
      res_hi = neg_hi_q ? hi_neg : acc_q[2*W-1:W];
    end
    res_lo = neg_lo_q ? lo_neg : acc_q[W-1:0];
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_mul_d = is_mul_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_next  = hi_q;
    lo_next  = lo_q;
    hilo_we  = 1'b0;
    stallreq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (op_mul) begin
            stallreq = 1'b1;
            state_d  = S_MUL;
            cnt_d    = CNT_W'(MUL_STEPS);
            acc_d    = {W'(0), b_mag};
            opb_d    = a_mag;
            is_mul_d = 1'b1;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg ^ b_neg;
          end else if (op_div) begin
            stallreq = 1'b1;
            is_mul_d = 1'b0;
            if (src_b == '0) begin
              // Divide by zero completes immediately with fixed results
              state_d  = S_DONE;
              acc_d    = {src_a, {W{1'b1}}};
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
            end else begin
              state_d  = S_DIV;
              cnt_d    = CNT_W'(W);
              acc_d    = {W'(0), a_mag};
              opb_d    = b_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
            end
          end else if (op_mthi) begin
            hilo_we = 1'b1;
            hi_next = src_a;
          end else if (op_mtlo) begin
            hilo_we = 1'b1;
            lo_next = src_a;
          end
        end
      end

      S_MUL: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          stallreq = 1'b1;
          acc_d    = mul_next;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DIV: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          stallreq = 1'b1;
          acc_d    = div_next;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (!annul) begin
          hilo_we = 1'b1;
          hi_next = res_hi;
          lo_next = res_lo;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_mul_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_mul_q <= is_mul_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_next;
      lo_q     <= lo_next;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: issue tasks push expected HI/LO writes,
// a negedge monitor pops and compares whenever hilo_we is seen.
module tb_muldiv_hilo;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4, annul;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;

  logic        stall1, busy1, done1, we1;
  logic [31:0] hi1, lo1, hin1, lon1;
  logic        stall4, busy4, done4, we4;
  logic [31:0] hi4, lo4, hin4, lon4;

  int checks = 0;
  int errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q4[$];

  always #5 clk = ~clk;

  muldiv_hilo #(.W(32), .MUL_BPC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .src_a(src_a), .src_b(src_b),
    .annul(annul), .stallreq(stall1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1),
    .hilo_we(we1), .hi_next(hin1), .lo_next(lon1)
  );

  muldiv_hilo #(.W(32), .MUL_BPC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .src_a(src_a), .src_b(src_b),
    .annul(1'b0), .stallreq(stall4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4),
    .hilo_we(we4), .hi_next(hin4), .lo_next(lon4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every HI/LO write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (we1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected_write actual=%h_%h required=no_write", hin1, lon1);
        end else begin
          logic [63:0] e1;
          e1 = q1.pop_front();
          if ({hin1, lon1} !== e1) begin
            errors++;
            $display("FAIL sb1_hilo_next actual=%h_%h required=%h_%h", hin1, lon1, e1[63:32], e1[31:0]);
          end
        end
      end
      if (we4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected_write actual=%h_%h required=no_write", hin4, lon4);
        end else begin
          logic [63:0] e4;
          e4 = q4.pop_front();
          if ({hin4, lon4} !== e4) begin
            errors++;
            $display("FAIL sb4_hilo_next actual=%h_%h required=%h_%h", hin4, lon4, e4[63:32], e4[31:0]);
          end
        end
      end
    end
  end

  // Issue one instruction; entered and left at #1 after a rising edge so calls chain without bubbles
  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int exp_stall,
                       input int exp_done, input string nm);
    int n, nd, k;
    bit ended;
    n = 0; nd = 0; k = 0; ended = 1'b0;
    if (sel) q4.push_back({eh, el});
    else     q1.push_back({eh, el});
    op = o; src_a = a; src_b = b;
    if (sel) start4 = 1'b1;
    else     start1 = 1'b1;
    while (!ended && k < 100) begin
      @(negedge clk);
      if (sel ? done4 : done1) nd++;
      if (sel ? stall4 : stall1) begin
        n++;
        // Operands are held by the pipeline, but the unit must not depend on them after acceptance
        if (k >= 1) begin
          src_a = ~a;
          src_b = ~b;
        end
      end else begin
        ended = 1'b1;
      end
      k++;
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=stall_after_%0d_cycles required=%0d", nm, k, exp_stall);
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({nm, "_done_pulses"}, 64'(nd), 64'(exp_done));
    chk({nm, "_hilo"}, sel ? {hi4, lo4} : {hi1, lo1}, {eh, el});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; annul = 1'b0;
    op = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_stallreq", 64'(stall1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_hilo_we", 64'(we1), 64'd0);
    chk("rst_hilo", {hi1, lo1}, 64'd0);
    chk("rst_hilo_next", {hin1, lon1}, 64'd0);
    chk("rst_dut4_state", {62'd0, stall4, busy4}, 64'd0);
    @(posedge clk);
    #1;

    issue(0, OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1, "mult_m3x7");
    issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1, "multu_max");
    issue(0, OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1, "divu_100_7");
    issue(0, OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1, "div_m7_2");
    issue(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1, "div_min_m1");
    issue(0, OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1,  1, "div_by_zero");
    issue(0, OP_MTHI,  32'hCAFE0000, 32'd0,        32'hCAFE0000, 32'hFFFFFFFF, 0,  0, "mthi");
    issue(0, OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30,       33, 1, "mult_m5xm6");
    issue(0, OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1, "div_7_m2");

    // Annul a divide in cycle 10: no write, HI/LO keep 1 / 0xFFFFFFFD
    op = OP_DIV; src_a = 32'd100; src_b = 32'd3; start1 = 1'b1;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stallreq", 64'(stall1), 64'd0);
    chk("annul_hilo_we", 64'(we1), 64'd0);
    @(posedge clk);
    #1 annul = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("annul_busy_after", 64'(busy1), 64'd0);
    chk("annul_done_after", 64'(done1), 64'd0);
    chk("annul_stall_after", 64'(stall1), 64'd0);
    chk("annul_hilo_kept", {hi1, lo1}, {32'd1, 32'hFFFFFFFD});
    @(posedge clk);
    #1;
    issue(0, OP_MTLO, 32'h00001234, 32'd0, 32'd1, 32'h00001234, 0, 0, "mtlo_after_annul");

    // Reset in cycle 5 of a multiply
    op = OP_MULT; src_a = 32'd9; src_b = 32'd9; start1 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy1), 64'd0);
    chk("midrst_stall", 64'(stall1), 64'd0);
    chk("midrst_hilo", {hi1, lo1}, 64'd0);
    @(posedge clk);
    #1;
    issue(0, OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1, "mult_6x7");

    // Four multiplier bits per cycle
    issue(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 9, 1, "bpc4_multu_max");
    issue(1, OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 9, 1, "bpc4_mult_m3x7");
    issue(1, OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1, "bpc4_divu");

    repeat (2) @(posedge clk);
    chk("sb1_drained", 64'(q1.size()), 64'd0);
    chk("sb4_drained", 64'(q4.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Parametrised iterative multiply/divide unit with architectural HI/LO registers, instantiated inside the EX stage. It executes MULT/MULTU/DIV/DIVU over several cycles and raises a stall request to the pipeline controller until the result is committed. It also executes MTHI/MTLO in a single cycle and exposes next-state HI/LO values for ID-stage forwarding.

## Interface
- W, 32: operand width; even, ≥4.
- MUL_BPC, 1: multiplier bits retired per cycle; must divide W (1, 2 or 4).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  EX holds a valid HI/LO-class instruction this cycle; held high while stalled.
- op  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes = no-op.
- src_a  in  W  rs operand (multiplicand, dividend, or MTHI/MTLO data).
- src_b  in  W  rt operand (multiplier or divisor).
- annul  in  1  abort the in-flight operation (flush).
- stallreq  out  1  combinational stall request to the pipeline controller.
- busy  out  1  state is MUL or DIV.
- done  out  1  high in the DONE state, i.e. the result commits at the end of this cycle.
- hi, lo  out  W each  architectural HI/LO registers.
- hilo_we  out  1  HI/LO are written at the end of this cycle.
- hi_next, lo_next  out  W each  values HI/LO hold after this edge; these are the forwarding source for ID.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with start and op MULT/MULTU: latch |a| and |b| (magnitudes only when signed), clear the accumulator, set cnt=W/MUL_BPC, and go to MUL. Sign flag = a[W-1]^b[W-1] for MULT, and 0 otherwise.
- MUL: each cycle add the partial products of the low MUL_BPC multiplier bits, then shift. Decrement cnt. At cnt=1 go to DONE.
- IDLE with start and op DIV/DIVU, divisor ≠0: latch magnitudes, set cnt=W, and go to DIV.
  - Quotient sign = a^b signs.
  - Remainder sign = dividend sign.
  - Unsigned variants use no signs.
- DIV: one restoring step per cycle, on a 2W-bit shift register, with one compare/subtract per cycle. At cnt=1 go to DONE.
- Divide by zero: go from IDLE directly to DONE. Result LO = all ones, HI = src_a.
- DONE: apply sign correction by two's-complement negation. Write HI (upper half or remainder) and LO (lower half or quotient), then go to IDLE.
  - Signed minimum / -1: LO = 1 followed by W-1 zeros, HI = 0. This is natural wrap; no trap.
- MTHI/MTLO in IDLE with start: write HI or LO with src_a at the edge. The state stays IDLE and no stall is raised.
- stallreq = (IDLE & start & op∈{MULT..DIVU} & ~annul) | ((MUL|DIV) & ~annul). It is 0 in DONE.
- annul in MUL/DIV or DONE: go to IDLE at the edge. No HI/LO write and hilo_we=0. Annul wins over completion.
- hilo_we=1 in DONE (not annulled) and for MTHI/MTLO in IDLE. Otherwise hi_next=hi and lo_next=lo.
- Operands are ignored while in MUL/DIV. They are latched only at acceptance.
- start with a new op in DONE is not a new op: it is the completing instruction still in EX. Acceptance occurs only in IDLE.

## Timing
- Reset values: state IDLE, hi=lo=0, stallreq=busy=done=hilo_we=0, hi_next=lo_next=0.
- Multiply: accept in cycle 0 (IDLE) and stay in MUL for W/MUL_BPC cycles. DONE follows in cycle W/MUL_BPC+1. stallreq is high for W/MUL_BPC+1 cycles.
- Divide: stallreq is high for W+1 cycles, and DONE follows in cycle W+1. Divide by zero stalls 1 cycle and is in DONE in cycle 1.
- MTHI/MTLO: 0 stall cycles. hi/lo update at the edge ending the issue cycle, and hi_next is valid in the same cycle.
- The new hi/lo are visible on the outputs the cycle after DONE. hi_next/lo_next carry them during DONE.
- Back-to-back ops: a new op can be accepted in the first IDLE cycle after DONE, with no bubble inside the unit.
- rst mid-operation: the unit returns to IDLE at the next edge, clears HI/LO to 0 and drops stallreq.

## Test plan
- W=32, MUL_BPC=1, MULT a=-3, b=7 -> stallreq high 33 cycles, done pulses once, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MUL_BPC=4, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> 9 stall cycles, HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> HI=2, LO=14 after 33 stall cycles. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV 5/0 -> 1 stall cycle, LO=0xFFFFFFFF, HI=5.
- DIV started, annul in cycle 10 -> IDLE next cycle, stallreq=0 in cycle 10, HI/LO unchanged. A following MTLO 0x1234 -> LO=0x1234, no stall, hi_next/lo_next correct in the same cycle.
- MULT in progress, rst in cycle 5 -> IDLE, hi=lo=0, busy=0 next cycle. A fresh MULT 6*7 then yields LO=42, HI=0.
